// File: rtl/core_pkg.sv
// core_pkg: types shared by the reservation stations and the result bus
// arbiter.
//   DEFAULT_STATION_INDEX_SIZE - default width of a station tag
//   RESULT_SIZE                - default result/bus data width
//   station_index_t            - station tag
//   result_bus_t               - one result bus beat (asserted, source, value)
package core_pkg;

    localparam int DEFAULT_STATION_INDEX_SIZE = 2;
    localparam int RESULT_SIZE                = 32;

    typedef logic [DEFAULT_STATION_INDEX_SIZE-1:0] station_index_t;

    typedef struct packed {
        logic                   asserted;
        station_index_t         source;
        logic [RESULT_SIZE-1:0] value;
    } result_bus_t;

endpackage

// File: rtl/result_bus_picker.sv
// result_bus_picker: combinational rotate-and-find-first-N selector.
// Scans stations starting at `start`, wrapping modulo STATION_COUNT, and
// hands the first BUS_COUNT ready stations to buses 0..BUS_COUNT-1 in scan
// order.
//   ready       - per-station result_ready
//   start       - station the scan begins at
//   grant_valid - bus k received a station
//   grant_index - station tag assigned to bus k
//   grant_mask  - one-hot-per-grant station mask
//   next_ptr    - station after the last grant (start when nothing granted)
module result_bus_picker #(
    parameter int STATION_COUNT      = 4,
    parameter int STATION_INDEX_SIZE = 2,
    parameter int BUS_COUNT          = 1
) (
    input  logic [STATION_COUNT-1:0]                     ready,
    input  logic [STATION_INDEX_SIZE-1:0]                start,
    output logic [BUS_COUNT-1:0]                         grant_valid,
    output logic [BUS_COUNT-1:0][STATION_INDEX_SIZE-1:0] grant_index,
    output logic [STATION_COUNT-1:0]                     grant_mask,
    output logic [STATION_INDEX_SIZE-1:0]                next_ptr
);

    always_comb begin
        int idx;
        int cnt;
        int last;
        grant_valid = '0;
        grant_index = '0;
        grant_mask  = '0;
        next_ptr    = start;
        idx         = 0;
        cnt         = 0;
        last        = 0;
        for (int i = 0; i < STATION_COUNT; i++) begin
            // start < STATION_COUNT, so one subtraction is enough to wrap
            idx = int'(start) + i;
            if (idx >= STATION_COUNT) idx = idx - STATION_COUNT;
            if (ready[idx] && cnt < BUS_COUNT) begin
                grant_valid[cnt] = 1'b1;
                grant_index[cnt] = STATION_INDEX_SIZE'(idx);
                grant_mask[idx]  = 1'b1;
                last             = idx;
                cnt              = cnt + 1;
            end
        end
        // explicit wrap keeps non-power-of-two station counts in range
        if (cnt != 0)
            next_ptr = (last == STATION_COUNT - 1) ? '0 : STATION_INDEX_SIZE'(last + 1);
    end

endmodule

// File: rtl/result_bus_arbiter.sv
// result_bus_arbiter: picks up to BUS_COUNT finished stations per cycle,
// frees them through reset_occupied and broadcasts their results on the
// common result buses one cycle later.
// Optional feature: RESULT_BUS_ROUND_ROBIN_EN selects a rotating priority
// pointer; without it the scan always starts at station 0.
//   clock          - rising-edge clock
//   reset          - synchronous active-high reset
//   result_ready   - station holds a finished result
//   result         - station result values
//   reset_occupied - combinational grant, frees the station at the next edge
//   bus_asserted   - bus carries a valid result this cycle
//   bus_source     - tag of the producing station
//   bus_value      - broadcast value
module result_bus_arbiter
    import core_pkg::*;
#(
    parameter int STATION_COUNT      = 4,
    parameter int STATION_INDEX_SIZE = DEFAULT_STATION_INDEX_SIZE,
    parameter int SIZE               = 32,
    parameter int BUS_COUNT          = 1
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic [STATION_COUNT-1:0]                     result_ready,
    input  logic [STATION_COUNT-1:0][SIZE-1:0]           result,
    output logic [STATION_COUNT-1:0]                     reset_occupied,
    output logic [BUS_COUNT-1:0]                         bus_asserted,
    output logic [BUS_COUNT-1:0][STATION_INDEX_SIZE-1:0] bus_source,
    output logic [BUS_COUNT-1:0][SIZE-1:0]               bus_value
);

    logic [STATION_INDEX_SIZE-1:0]                pointer;
    logic [STATION_INDEX_SIZE-1:0]                next_ptr;
    logic [BUS_COUNT-1:0]                         grant_valid;
    logic [BUS_COUNT-1:0][STATION_INDEX_SIZE-1:0] grant_index;
    logic [STATION_COUNT-1:0]                     grant_mask;

    result_bus_picker #(
        .STATION_COUNT      (STATION_COUNT),
        .STATION_INDEX_SIZE (STATION_INDEX_SIZE),
        .BUS_COUNT          (BUS_COUNT)
    ) u_picker (
        .ready       (result_ready),
        .start       (pointer),
        .grant_valid (grant_valid),
        .grant_index (grant_index),
        .grant_mask  (grant_mask),
        .next_ptr    (next_ptr)
    );

`ifdef RESULT_BUS_ROUND_ROBIN_EN
    // next_ptr equals pointer when nothing was granted, so it simply holds
    always_ff @(posedge clock) begin
        if (reset) pointer <= '0;
        else       pointer <= next_ptr;
    end
`else
    assign pointer = '0;
    logic unused_next_ptr;
    assign unused_next_ptr = ^next_ptr;
`endif

    // A grant during reset is dropped so the station keeps its result.
    assign reset_occupied = reset ? '0 : grant_mask;

    always_ff @(posedge clock) begin
        if (reset) begin
            bus_asserted <= '0;
            bus_source   <= '0;
            bus_value    <= '0;
        end else begin
            for (int k = 0; k < BUS_COUNT; k++) begin
                bus_asserted[k] <= grant_valid[k];
                // idle buses keep their last source/value
                if (grant_valid[k]) begin
                    bus_source[k] <= grant_index[k];
                    bus_value[k]  <= result[grant_index[k]];
                end
            end
        end
    end

endmodule

// File: tb/tb_result_bus_arbiter.sv
module tb_result_bus_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // inst 0: 4 stations, 1 bus
    logic [3:0]        rdy4 = '0;
    logic [3:0][31:0]  res4 = '0;
    logic [3:0]        ro4;
    logic [0:0]        ba4;
    logic [0:0][1:0]   bs4;
    logic [0:0][31:0]  bv4;
    // inst 1: 4 stations, 2 buses
    logic [3:0]        rdyB = '0;
    logic [3:0][31:0]  resB = '0;
    logic [3:0]        roB;
    logic [1:0]        baB;
    logic [1:0][1:0]   bsB;
    logic [1:0][31:0]  bvB;
    // inst 2: 5 stations, 1 bus
    logic [4:0]        rdy5 = '0;
    logic [4:0][31:0]  res5 = '0;
    logic [4:0]        ro5;
    logic [0:0]        ba5;
    logic [0:0][2:0]   bs5;
    logic [0:0][31:0]  bv5;

    result_bus_arbiter #(.STATION_COUNT(4), .STATION_INDEX_SIZE(2), .SIZE(32), .BUS_COUNT(1)) d4 (
        .clock(clock), .reset(reset), .result_ready(rdy4), .result(res4),
        .reset_occupied(ro4), .bus_asserted(ba4), .bus_source(bs4), .bus_value(bv4));
    result_bus_arbiter #(.STATION_COUNT(4), .STATION_INDEX_SIZE(2), .SIZE(32), .BUS_COUNT(2)) d2 (
        .clock(clock), .reset(reset), .result_ready(rdyB), .result(resB),
        .reset_occupied(roB), .bus_asserted(baB), .bus_source(bsB), .bus_value(bvB));
    result_bus_arbiter #(.STATION_COUNT(5), .STATION_INDEX_SIZE(3), .SIZE(32), .BUS_COUNT(1)) d5 (
        .clock(clock), .reset(reset), .result_ready(rdy5), .result(res5),
        .reset_occupied(ro5), .bus_asserted(ba5), .bus_source(bs5), .bus_value(bv5));

`ifdef RESULT_BUS_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int       m_ptr [3];
    bit       m_ba  [3][2];
    int       m_src [3][2];
    bit [31:0] m_val [3][2];
    int       n_ptr [3];
    bit       n_ba  [3][2];
    int       n_src [3][2];
    bit [31:0] n_val [3][2];

    // Scan order is a list of station numbers; the first bc ready ones win.
    task automatic model_pick(input int sc, input int bc, input int ptr, input logic [7:0] rdy,
                              output logic [7:0] mask, output int idx[2], output int ng);
        int order[$];
        mask = '0;
        ng = 0;
        idx[0] = 0;
        idx[1] = 0;
        for (int i = 0; i < sc; i++) order.push_back((ptr + i) % sc);
        foreach (order[j]) begin
            if (rdy[order[j]] && ng < bc) begin
                idx[ng] = order[j];
                mask[order[j]] = 1'b1;
                ng++;
            end
        end
    endtask

    task automatic check_inst(input int id, input int sc, input int bc,
                              input logic [7:0] rdy, input logic [7:0] ro, input logic [1:0] ba,
                              input int s0, input int s1, input logic [31:0] v0, input logic [31:0] v1,
                              input logic [7:0][31:0] res);
        logic [7:0] mask;
        int idx[2];
        int ng;
        int ptr;
        int act_s[2];
        logic [31:0] act_v[2];
        act_s[0] = s0; act_s[1] = s1;
        act_v[0] = v0; act_v[1] = v1;
        ptr = RR ? m_ptr[id] : 0;
        model_pick(sc, bc, ptr, rdy, mask, idx, ng);
        if (reset) mask = '0;
        chk($sformatf("inst%0d reset_occupied", id), 64'(ro), 64'(mask));
        for (int k = 0; k < bc; k++) begin
            chk($sformatf("inst%0d bus_asserted[%0d]", id, k), 64'(ba[k]), 64'(m_ba[id][k]));
            chk($sformatf("inst%0d bus_source[%0d]", id, k), 64'(act_s[k]), 64'(m_src[id][k]));
            chk($sformatf("inst%0d bus_value[%0d]", id, k), 64'(act_v[k]), 64'(m_val[id][k]));
        end
        n_ptr[id] = m_ptr[id];
        for (int k = 0; k < 2; k++) begin
            n_ba[id][k] = m_ba[id][k]; n_src[id][k] = m_src[id][k]; n_val[id][k] = m_val[id][k];
        end
        if (reset) begin
            n_ptr[id] = 0;
            for (int k = 0; k < 2; k++) begin
                n_ba[id][k] = 0; n_src[id][k] = 0; n_val[id][k] = 0;
            end
        end else begin
            for (int k = 0; k < bc; k++) begin
                n_ba[id][k] = (k < ng);
                if (k < ng) begin
                    n_src[id][k] = idx[k];
                    n_val[id][k] = res[idx[k]];
                end
            end
            if (ng > 0) n_ptr[id] = (idx[ng-1] + 1) % sc;
        end
    endtask

    // compare process: check at negedge, advance model at posedge
    initial begin
        logic [7:0][31:0] r;
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 2; k++) m_val[i][k] = 0;
        @(posedge clock);
        forever begin
            @(negedge clock);
            r = '0; for (int s = 0; s < 4; s++) r[s] = res4[s];
            check_inst(0, 4, 1, 8'(rdy4), 8'(ro4), {1'b0, ba4}, int'(bs4[0]), 0, bv4[0], 32'h0, r);
            r = '0; for (int s = 0; s < 4; s++) r[s] = resB[s];
            check_inst(1, 4, 2, 8'(rdyB), 8'(roB), baB, int'(bsB[0]), int'(bsB[1]), bvB[0], bvB[1], r);
            r = '0; for (int s = 0; s < 5; s++) r[s] = res5[s];
            check_inst(2, 5, 1, 8'(rdy5), 8'(ro5), {1'b0, ba5}, int'(bs5[0]), 0, bv5[0], 32'h0, r);
            @(posedge clock);
            m_ptr = n_ptr; m_ba = n_ba; m_src = n_src; m_val = n_val;
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        cyc(); cyc();
        reset = 1'b0;
        @(negedge clock);
        chk("reset ro4", 64'(ro4), 64'h0);
        chk("reset ba4", 64'(ba4), 64'h0);
        chk("reset bs4", 64'(bs4[0]), 64'h0);
        chk("reset bv4", 64'(bv4[0]), 64'h0);

        // single ready
        cyc(); rdy4 = 4'b0100; res4[2] = 32'h0000_00AB;
        @(negedge clock); chk("single ro4", 64'(ro4), 64'h4);
        cyc(); rdy4 = 4'b0000;
        @(negedge clock);
        chk("single ba4", 64'(ba4), 64'h1);
        chk("single bs4", 64'(bs4[0]), 64'h2);
        chk("single bv4", 64'(bv4[0]), 64'hAB);
        cyc();
        @(negedge clock);
        chk("single ba4 drop", 64'(ba4), 64'h0);
        chk("single bs4 hold", 64'(bs4[0]), 64'h2);

        // contention from pointer 0 + two-bus grant
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0;
        for (int s = 0; s < 4; s++) begin
            res4[s] = 32'h10 + s;
            resB[s] = 32'h20 + s;
        end
        rdy4 = 4'b1111; rdyB = 4'b1010;
        @(negedge clock);
        chk("cont ro4 c0", 64'(ro4), 64'h1);
        chk("two ro", 64'(roB), 64'hA);
        cyc(); rdy4 = 4'b1110; rdyB = 4'b0000;
        @(negedge clock);
        chk("cont ro4 c1", 64'(ro4), 64'h2);
        chk("cont bs4 c1", 64'(bs4[0]), 64'h0);
        chk("cont bv4 c1", 64'(bv4[0]), 64'h10);
        chk("two ba", 64'(baB), 64'h3);
        chk("two bs0", 64'(bsB[0]), 64'h1);
        chk("two bs1", 64'(bsB[1]), 64'h3);
        chk("two bv1", 64'(bvB[1]), 64'h23);
        cyc(); rdy4 = 4'b1100;
        @(negedge clock);
        chk("cont ro4 c2", 64'(ro4), 64'h4);
        chk("cont bs4 c2", 64'(bs4[0]), 64'h1);
        cyc(); rdy4 = 4'b1000;
        @(negedge clock);
        chk("cont ro4 c3", 64'(ro4), 64'h8);
        chk("cont bs4 c3", 64'(bs4[0]), 64'h2);
        cyc(); rdy4 = 4'b0000;
        @(negedge clock);
        chk("cont bs4 c4", 64'(bs4[0]), 64'h3);
        chk("cont bv4 c4", 64'(bv4[0]), 64'h13);

        // five stations: wrap after granting station 4
        for (int s = 0; s < 5; s++) res5[s] = 32'h30 + s;
        cyc(); rdy5 = 5'b10000;
        @(negedge clock); chk("wrap ro5 a", 64'(ro5), 64'h10);
        cyc(); rdy5 = 5'b10001;
        @(negedge clock);
        chk("wrap ro5 b", 64'(ro5), 64'h01);
        chk("wrap bs5 b", 64'(bs5[0]), 64'h4);
        cyc(); rdy5 = 5'b10000;
        @(negedge clock); chk("wrap ro5 c", 64'(ro5), 64'h10);
        cyc(); rdy5 = 5'b11000;
        @(negedge clock); chk("prio ro5 a", 64'(ro5), 64'h08);
        cyc(); rdy5 = 5'b11000;
        @(negedge clock);
        chk("prio ro5 b", 64'(ro5), RR ? 64'h10 : 64'h08);
        chk("prio bs5 b", 64'(bs5[0]), 64'h3);
        cyc(); rdy5 = 5'b00000;
        @(negedge clock);
        chk("prio bs5 c", 64'(bs5[0]), RR ? 64'h4 : 64'h3);

        // reset in the same cycle as a ready station
        cyc(); reset = 1'b1; rdy4 = 4'b0010;
        @(negedge clock); chk("rst ro4 suppressed", 64'(ro4), 64'h0);
        cyc(); reset = 1'b0;
        @(negedge clock);
        chk("rst ba4 cleared", 64'(ba4), 64'h0);
        chk("rst ro4 after", 64'(ro4), 64'h2);
        cyc(); rdy4 = 4'b0000;
        @(negedge clock);
        chk("rst ba4 grant", 64'(ba4), 64'h1);
        chk("rst bs4 grant", 64'(bs4[0]), 64'h1);
        chk("rst bv4 grant", 64'(bv4[0]), 64'h11);

        // idle, then confirm the pointer did not move
        for (int i = 0; i < 10; i++) begin
            cyc();
            @(negedge clock);
            chk("idle ro4", 64'(ro4), 64'h0);
            chk("idle ba4", 64'(ba4), 64'h0);
        end
        cyc(); rdy4 = 4'b1111;
        @(negedge clock); chk("idle order ro4", 64'(ro4), RR ? 64'h4 : 64'h1);
        cyc(); rdy4 = 4'b0000;
        cyc(); cyc();
        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
